// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions used by the branch predictor.
//   XLEN                    : default address/data width
//   CTR_BITS                : default direction-counter width
//   btb_entry_t             : one branch-target-buffer entry
//   ctrWeakTaken/NotTaken   : counter init values as functions of counter width
package riscv_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned CTR_BITS = 2;

    // The tag is held zero-extended to XLEN so the layout does not depend on
    // the table depth; only the low XLEN-IDX-2 bits are ever non-zero.
    typedef struct packed {
        logic                valid;
        logic [XLEN-1:0]     tag;
        logic [XLEN-1:0]     target;
        logic [CTR_BITS-1:0] ctr;
        logic                isJump;
    } btb_entry_t;

    function automatic int unsigned ctrWeakTaken(input int unsigned bits);
        return 32'd1 << (bits - 32'd1);
    endfunction

    function automatic int unsigned ctrWeakNotTaken(input int unsigned bits);
        return ctrWeakTaken(bits) - 32'd1;
    endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Up/down saturating counter step: returns the next value of count.
//   count       : current value
//   inc / dec   : step request (both or neither -> hold)
//   nextCount_c : next value, clamped to [0, all-ones]
module bp_sat_counter #(
    parameter int unsigned WIDTH = 2
) (
    input  logic [WIDTH-1:0] count,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] nextCount_c
);

    localparam logic [WIDTH-1:0] MAX_VAL = '1;

    always_comb begin
        nextCount_c = count;
        if (inc && !dec && (count != MAX_VAL)) begin
            nextCount_c = count + WIDTH'(1);
        end else if (dec && !inc && (count != '0)) begin
            nextCount_c = count - WIDTH'(1);
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: direct-mapped BTB with per-entry saturating
// direction counter. Predicts in Fetch, resolves and updates in Execute.
//   clk, reset          : clock, asynchronous active-high reset
//   f_pc                : Fetch lookup PC
//   f_pred_taken/target : combinational prediction for f_pc
//   e_*                 : resolved Execute-stage instruction and its piped prediction
//   e_mispredict        : combinational redirect request
//   e_redirect_pc       : corrected PC
//   stat_clear          : synchronous clear of the statistics
//   stat_branches       : resolved control-flow instruction count (saturating)
//   stat_mispredicts    : misprediction count (saturating)
module branch_predictor #(
    parameter int unsigned XLEN     = riscv_pkg::XLEN,
    parameter int unsigned ENTRIES  = 16,
    parameter int unsigned CTR_BITS = riscv_pkg::CTR_BITS
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] f_pc,
    output logic            f_pred_taken,
    output logic [XLEN-1:0] f_pred_target,
    input  logic            e_valid,
    input  logic [XLEN-1:0] e_pc,
    input  logic            e_is_branch,
    input  logic            e_is_jump,
    input  logic            e_taken,
    input  logic [XLEN-1:0] e_target,
    input  logic            e_pred_taken,
    input  logic [XLEN-1:0] e_pred_target,
    output logic            e_mispredict,
    output logic [XLEN-1:0] e_redirect_pc,
    input  logic            stat_clear,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
);

    import riscv_pkg::*;

    localparam int unsigned IDX     = $clog2(ENTRIES);
    localparam int unsigned TAG_LSB = IDX + 2;

    localparam logic [CTR_BITS-1:0] CTR_WT      = CTR_BITS'(ctrWeakTaken(CTR_BITS));
    localparam logic [CTR_BITS-1:0] CTR_WNT     = CTR_BITS'(ctrWeakNotTaken(CTR_BITS));
    localparam logic [CTR_BITS-1:0] CTR_SAT_MAX = '1;

    btb_entry_t btb [ENTRIES];

    logic [IDX-1:0]      fIdx;
    logic [IDX-1:0]      eIdx;
    logic [XLEN-1:0]     fTag;
    logic [XLEN-1:0]     eTag;
    logic                fHit;
    logic                eHit;
    logic                isCf;
    logic                cfHit;
    logic                allocate;
    logic                invalidate;
    logic [CTR_BITS-1:0] ctrNext [ENTRIES];
    logic [31:0]         branchNext;
    logic [31:0]         mispNext;

    // Address split: word index selects the entry, the rest is the tag.
    always_comb begin
        fIdx = f_pc[IDX+1:2];
        eIdx = e_pc[IDX+1:2];
        fTag = XLEN'(f_pc >> TAG_LSB);
        eTag = XLEN'(e_pc >> TAG_LSB);
    end

    // Fetch lookup; reads the registered table, so same-cycle writes are not seen.
    always_comb begin
        fHit          = btb[fIdx].valid && (btb[fIdx].tag == fTag);
        f_pred_taken  = fHit && (btb[fIdx].isJump || btb[fIdx].ctr[CTR_BITS-1]);
        f_pred_target = f_pred_taken ? btb[fIdx].target : f_pc + XLEN'(4);
    end

    // Execute resolution and update classification.
    always_comb begin
        isCf       = e_valid && (e_is_branch || e_is_jump);
        eHit       = btb[eIdx].valid && (btb[eIdx].tag == eTag);
        cfHit      = isCf && eHit;
        allocate   = isCf && !eHit && e_taken;
        invalidate = e_valid && !isCf && eHit;

        e_mispredict = (isCf && ((e_pred_taken != e_taken) ||
                                 (e_taken && (e_pred_target != e_target))))
                    || (e_valid && !isCf && e_pred_taken);
        e_redirect_pc = (isCf && e_taken) ? e_target : e_pc + XLEN'(4);
    end

    // Per-entry direction counter step; only committed for the entry being updated.
    for (genvar i = 0; i < ENTRIES; i++) begin : gCtr
        bp_sat_counter #(
            .WIDTH(CTR_BITS)
        ) uCtr (
            .count      (btb[i].ctr),
            .inc        (e_taken),
            .dec        (!e_taken),
            .nextCount_c(ctrNext[i])
        );
    end

    // BTB storage, flop array so reset can clear every entry asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                btb[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WNT, isJump: 1'b0};
            end
        end else if (allocate) begin
            btb[eIdx] <= '{valid:  1'b1,
                           tag:    eTag,
                           target: e_target,
                           ctr:    e_is_jump ? CTR_SAT_MAX : CTR_WT,
                           isJump: e_is_jump};
        end else if (cfHit) begin
            btb[eIdx].ctr    <= ctrNext[eIdx];
            btb[eIdx].isJump <= e_is_jump;
            if (e_taken) begin
                btb[eIdx].target <= e_target;
            end
        end else if (invalidate) begin
            btb[eIdx].valid <= 1'b0;
        end
    end

    // Statistics: saturating up-counters, clear wins over increment.
    bp_sat_counter #(
        .WIDTH(32)
    ) uBranchCnt (
        .count      (stat_branches),
        .inc        (isCf),
        .dec        (1'b0),
        .nextCount_c(branchNext)
    );

    bp_sat_counter #(
        .WIDTH(32)
    ) uMispCnt (
        .count      (stat_mispredicts),
        .inc        (e_mispredict),
        .dec        (1'b0),
        .nextCount_c(mispNext)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else if (stat_clear) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            stat_branches    <= branchNext;
            stat_mispredicts <= mispNext;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: stimulus pushes expected values,
// a monitor on the falling edge pops and compares them.
module tb_branch_predictor;

    logic        clk;
    logic        reset;
    logic [31:0] f_pc;
    logic        f_pred_taken;
    logic [31:0] f_pred_target;
    logic        e_valid;
    logic [31:0] e_pc;
    logic        e_is_branch;
    logic        e_is_jump;
    logic        e_taken;
    logic [31:0] e_target;
    logic        e_pred_taken;
    logic [31:0] e_pred_target;
    logic        e_mispredict;
    logic [31:0] e_redirect_pc;
    logic        stat_clear;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    branch_predictor dut (
        .clk             (clk),
        .reset           (reset),
        .f_pc            (f_pc),
        .f_pred_taken    (f_pred_taken),
        .f_pred_target   (f_pred_target),
        .e_valid         (e_valid),
        .e_pc            (e_pc),
        .e_is_branch     (e_is_branch),
        .e_is_jump       (e_is_jump),
        .e_taken         (e_taken),
        .e_target        (e_target),
        .e_pred_taken    (e_pred_taken),
        .e_pred_target   (e_pred_target),
        .e_mispredict    (e_mispredict),
        .e_redirect_pc   (e_redirect_pc),
        .stat_clear      (stat_clear),
        .stat_branches   (stat_branches),
        .stat_mispredicts(stat_mispredicts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int {S_PTAKEN, S_PTARGET, S_MISP, S_REDIR, S_BRANCHES, S_MISPS} sig_e;
    typedef struct {
        sig_e        sig;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sbq[$];
    int   assertCount = 0;
    int   failCount   = 0;

    function automatic logic [31:0] actualOf(input sig_e s);
        case (s)
            S_PTAKEN:   return {31'd0, f_pred_taken};
            S_PTARGET:  return f_pred_target;
            S_MISP:     return {31'd0, e_mispredict};
            S_REDIR:    return e_redirect_pc;
            S_BRANCHES: return stat_branches;
            default:    return stat_mispredicts;
        endcase
    endfunction

    // Monitor: everything queued for this cycle is checked on the falling edge.
    exp_t        cur;
    logic [31:0] act;
    initial begin
        forever begin
            @(negedge clk);
            while (sbq.size() > 0) begin
                cur = sbq.pop_front();
                act = actualOf(cur.sig);
                assertCount++;
                if (act !== cur.exp) begin
                    failCount++;
                    $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)",
                             cur.name, act, cur.exp, $time);
                end
            end
        end
    end

    task automatic expectSig(input sig_e s, input logic [31:0] v, input string n);
        exp_t e;
        e.sig  = s;
        e.exp  = v;
        e.name = n;
        sbq.push_back(e);
    endtask

    task automatic expectLookup(input logic [31:0] pc, input logic taken,
                                input logic [31:0] target, input string n);
        f_pc = pc;
        expectSig(S_PTAKEN, {31'd0, taken}, {n, ".taken"});
        expectSig(S_PTARGET, target, {n, ".target"});
    endtask

    task automatic expectStats(input logic [31:0] br, input logic [31:0] mp, input string n);
        expectSig(S_BRANCHES, br, {n, ".branches"});
        expectSig(S_MISPS, mp, {n, ".mispredicts"});
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic br,
                         input logic jmp, input logic tk, input logic [31:0] tgt,
                         input logic ptk, input logic [31:0] ptgt);
        e_valid       = v;
        e_pc          = pc;
        e_is_branch   = br;
        e_is_jump     = jmp;
        e_taken       = tk;
        e_target      = tgt;
        e_pred_taken  = ptk;
        e_pred_target = ptgt;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        stat_clear = 1'b0;
        f_pc       = 32'h0;
        idle();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // 1: reset state; a bubble carrying a stale prediction is not a redirect
        e_pred_taken = 1'b1;
        expectLookup(32'h0, 1'b0, 32'h4, "rst_pc0");
        expectSig(S_MISP, 32'd0, "bubble_misp");
        expectStats(32'd0, 32'd0, "rst_stats");
        step();
        idle();
        expectLookup(32'h40, 1'b0, 32'h44, "rst_pc40");
        step();
        expectLookup(32'h3C, 1'b0, 32'h40, "rst_pc3c");
        step();

        // 2: first taken branch allocates; same-cycle lookup sees old contents
        drive(1'b1, 32'h40, 1'b1, 1'b0, 1'b1, 32'h20, 1'b0, 32'h44);
        expectLookup(32'h40, 1'b0, 32'h44, "alloc_nobypass");
        expectSig(S_MISP, 32'd1, "alloc_misp");
        expectSig(S_REDIR, 32'h20, "alloc_redir");
        step();
        idle();
        expectLookup(32'h40, 1'b1, 32'h20, "alloc_lookup");
        expectStats(32'd1, 32'd1, "alloc_stats");
        step();

        // 3: hysteresis, ctr 2 -> 3 -> 3 -> 2 -> 1
        repeat (2) begin
            drive(1'b1, 32'h40, 1'b1, 1'b0, 1'b1, 32'h20, 1'b1, 32'h20);
            expectSig(S_MISP, 32'd0, "hyst_taken_misp");
            step();
        end
        drive(1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h20);
        expectSig(S_MISP, 32'd1, "hyst_nt1_misp");
        expectSig(S_REDIR, 32'h44, "hyst_nt1_redir");
        step();
        idle();
        expectLookup(32'h40, 1'b1, 32'h20, "hyst_nt1_lookup");
        step();
        drive(1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h20);
        expectSig(S_MISP, 32'd1, "hyst_nt2_misp");
        step();
        idle();
        expectLookup(32'h40, 1'b0, 32'h44, "hyst_nt2_lookup");
        expectStats(32'd5, 32'd3, "hyst_stats");
        step();

        // 4: JAL at 0x100 (same index as 0x40) is predicted taken regardless of ctr
        drive(1'b1, 32'h100, 1'b0, 1'b1, 1'b1, 32'h200, 1'b0, 32'h104);
        expectSig(S_MISP, 32'd1, "jal_misp");
        expectSig(S_REDIR, 32'h200, "jal_redir");
        step();
        repeat (4) begin
            drive(1'b1, 32'h100, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h104);
            expectSig(S_MISP, 32'd0, "jal_dec_misp");
            step();
        end
        idle();
        expectLookup(32'h100, 1'b1, 32'h200, "jal_ctr0_lookup");
        step();
        expectLookup(32'h40, 1'b0, 32'h44, "jal_evicted_40");
        expectStats(32'd10, 32'd4, "jal_stats");
        step();

        // 5: aliasing between 0x40 and 0x80, then eviction; wrong-target redirect
        drive(1'b1, 32'h40, 1'b1, 1'b0, 1'b1, 32'h20, 1'b0, 32'h44);
        expectSig(S_MISP, 32'd1, "alias_alloc40_misp");
        step();
        idle();
        expectLookup(32'h40, 1'b1, 32'h20, "alias_hit40");
        step();
        expectLookup(32'h80, 1'b0, 32'h84, "alias_miss80");
        step();
        drive(1'b1, 32'h80, 1'b1, 1'b0, 1'b1, 32'h300, 1'b0, 32'h84);
        expectSig(S_MISP, 32'd1, "alias_alloc80_misp");
        expectSig(S_REDIR, 32'h300, "alias_alloc80_redir");
        expectLookup(32'h80, 1'b0, 32'h84, "alias_80_nobypass");
        step();
        idle();
        expectLookup(32'h80, 1'b1, 32'h300, "alias_hit80");
        step();
        drive(1'b1, 32'h80, 1'b1, 1'b0, 1'b1, 32'h340, 1'b1, 32'h300);
        expectSig(S_MISP, 32'd1, "wrong_target_misp");
        expectSig(S_REDIR, 32'h340, "wrong_target_redir");
        step();
        idle();
        expectLookup(32'h80, 1'b1, 32'h340, "wrong_target_lookup");
        step();
        expectLookup(32'h40, 1'b0, 32'h44, "alias_evicted40");
        expectStats(32'd13, 32'd7, "alias_stats");
        step();

        // 6: stale entry on a non-branch, then statistics clear
        drive(1'b1, 32'h40, 1'b1, 1'b0, 1'b1, 32'h20, 1'b0, 32'h44);
        expectSig(S_MISP, 32'd1, "stale_alloc_misp");
        step();
        drive(1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h20);
        expectSig(S_MISP, 32'd1, "stale_misp");
        expectSig(S_REDIR, 32'h44, "stale_redir");
        step();
        idle();
        expectLookup(32'h40, 1'b0, 32'h44, "stale_invalidated");
        step();
        drive(1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h44);
        expectSig(S_MISP, 32'd0, "nonbranch_ok_misp");
        step();
        idle();
        expectStats(32'd14, 32'd9, "pre_clear_stats");
        step();
        stat_clear = 1'b1;
        drive(1'b1, 32'h48, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h4C);
        expectSig(S_MISP, 32'd1, "clear_cycle_misp");
        expectSig(S_REDIR, 32'h4C, "clear_cycle_redir");
        step();
        stat_clear = 1'b0;
        idle();
        expectStats(32'd0, 32'd0, "clear_stats");
        step();
        drive(1'b1, 32'h48, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h4C);
        expectSig(S_MISP, 32'd0, "post_clear_misp");
        step();
        idle();
        expectStats(32'd1, 32'd0, "post_clear_stats");
        step();
        step();

        assertCount++;
        if (sbq.size() != 0) begin
            failCount++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor for the 5-stage RISC-V pipeline. It predicts in Fetch, using a direct-mapped branch target buffer (BTB) with a saturating direction counter per entry. It resolves in Execute: it flags mispredictions, supplies the corrected PC, and keeps hit/miss statistics. It replaces the "always not-taken, flush on PCSrcE" policy. The pipeline selects `f_pred_target` in Fetch, and on `e_mispredict` it redirects to `e_redirect_pc` and flushes D/E.

## Interface
Parameters:
- `XLEN`, 32, address/data width.
- `ENTRIES`, 16, number of BTB entries; power of two, ≥2; `IDX = log2(ENTRIES)`.
- `CTR_BITS`, 2, width of the direction counter; ≥1.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `f_pc`  in  XLEN  Fetch PC being looked up.
- `f_pred_taken`  out  1  prediction for `f_pc` (combinational).
- `f_pred_target`  out  XLEN  predicted target; equals `f_pc+4` when not taken.
- `e_valid`  in  1  the Execute-stage instruction is real (not a bubble or flushed).
- `e_pc`  in  XLEN  PC of the Execute instruction.
- `e_is_branch`  in  1  instruction is a conditional branch.
- `e_is_jump`  in  1  instruction is JAL/JALR.
- `e_taken`  in  1  resolved direction (1 for jumps).
- `e_target`  in  XLEN  resolved target.
- `e_pred_taken`  in  1  prediction made in Fetch for this instruction, piped F→E.
- `e_pred_target`  in  XLEN  prediction target made in Fetch, piped F→E.
- `e_mispredict`  out  1  redirect request (combinational).
- `e_redirect_pc`  out  XLEN  corrected PC.
- `stat_clear`  in  1  synchronous clear of the statistics counters.
- `stat_branches`  out  32  count of resolved control-flow instructions.
- `stat_mispredicts`  out  32  count of mispredictions.

## Operation
- Address fields: index = `pc[IDX+1:2]`; tag = `pc[XLEN-1:IDX+2]`.
- Entry contents: `valid`, `tag`, `target[XLEN]`, `ctr[CTR_BITS]`, `is_jump`.
- Lookup: `hit = valid && tag match`. `f_pred_taken = hit && (is_jump || ctr[MSB])`.
- Definitions used below:
  - `cf = e_valid && (e_is_branch || e_is_jump)`.
  - `WT` (weak-taken) = `1<<(CTR_BITS-1)`.
  - `WNT` (weak-not-taken) = `WT-1`.
  - `SAT_MAX` = all counter bits set (saturated taken).
- Misprediction: `e_mispredict = cf && (e_pred_taken != e_taken || (e_taken && e_pred_target != e_target))`, or `e_valid && !cf && e_pred_taken` (stale entry on a non-branch).
- `e_redirect_pc = (cf && e_taken) ? e_target : e_pc+4`. The value is don't-care when `e_mispredict` is 0.
- Update rules, applied at the clock edge:
  - `cf` and hit: the counter increments if taken, decrements if not, saturating at 0 and `SAT_MAX`. The target is overwritten when taken. `is_jump` takes the value of `e_is_jump`.
  - `cf` and miss and taken: allocate the entry, overwriting any previous occupant. Set `valid=1` and write the tag and target. Set `ctr = SAT_MAX` for a jump, `WT` for a branch. Set `is_jump = e_is_jump`.
  - `cf` and miss and not taken: no write.
  - `e_valid && !cf` and hit: clear `valid` of the entry.
- Statistics:
  - `stat_branches` increments on each `cf`.
  - `stat_mispredicts` increments on each `e_mispredict`.
  - Both saturate at `32'hFFFF_FFFF`.
  - `stat_clear` has priority over an increment in the same cycle.

## Timing
- Lookup is zero-latency combinational from `f_pc`.
- Updates take effect at the clock edge. A lookup of the index being written in the same cycle returns the old contents; there is no bypass.
- `e_mispredict` and `e_redirect_pc` are combinational from the E inputs. The pipeline registers the redirect in the same cycle as the existing PCSrcE path.
- Stalls: the pipeline holds the E inputs stable or drives `e_valid=0`. An update with `e_valid=1` is applied once per cycle it is asserted, so the pipeline drives `e_valid=0` while E is stalled.
- Reset, asynchronous and valid at any time, including in the middle of an update:
  - all entries are cleared to `valid=0`, `ctr=WNT`, `is_jump=0`;
  - both statistics counters go to 0;
  - the outputs become `f_pred_taken=0`, `f_pred_target=f_pc+4`, and `e_mispredict` follows its inputs.

## Structure
- Shared package `riscv_pkg`:
  - the `XLEN` default;
  - the `btb_entry_t` struct;
  - the `WT`/`WNT` counter-init constants, as functions of `CTR_BITS`.
- Sub-module `bp_sat_counter`: a parametrised up/down saturating counter. It is instantiated per entry, and with width 32 for the statistics counters.
- Storage is a flop array (not RAM), so reset can clear it asynchronously.

## Test plan
All scenarios use the default parameters unless stated.
1. Reset, then look up `f_pc` = 0x0, 0x40, 0x3C → `f_pred_taken=0` and target = pc+4 in every case; both statistics counters read 0.
2. Branch at 0x40 resolved taken to 0x20 with `e_pred_taken=0`:
   - the same cycle → `e_mispredict=1`, `e_redirect_pc=0x20`;
   - next cycle, `f_pc=0x40` → predicted taken, target 0x20;
   - `stat_mispredicts=1`.
3. Counter hysteresis at 0x40:
   - taken ×2 → ctr=3;
   - not-taken ×1 → still predicted taken;
   - second not-taken → ctr=1, `f_pred_taken=0`.
4. JAL at 0x100 to 0x200 allocates with `is_jump=1`. Then force ctr to 0 via four not-taken updates with `e_is_jump=1` and `e_taken=0` (illegal stimulus, used only to reach ctr=0) → still predicted taken to 0x200.
5. Aliasing: allocate 0x40 → taken; 0x80 shares index 0 with a different tag → lookup misses. Then a taken update at 0x80 evicts it, and 0x40 now misses.
6. Stale-entry path and clear:
   - non-branch at 0x40 with `e_pred_taken=1` → `e_mispredict=1`, `e_redirect_pc=0x44`, and the entry is invalidated on the next lookup;
   - `stat_clear` asserted together with an increment → the counters read 0.
